// File: rtl/prng_pkg.sv
// Shared constants and the XNOR LFSR step function for the PRNG bank.
package prng_pkg;

  localparam logic [1:0] REG_VALUE = 2'd0;
  localparam logic [1:0] REG_SEED  = 2'd1;
  localparam logic [1:0] REG_CTRL  = 2'd2;
  localparam logic [1:0] REG_COUNT = 2'd3;

  localparam int CTRL_RUN = 0;
  localparam int CTRL_AOR = 1;

  // Fibonacci XNOR step over the low 'width' bits; bits above width stay zero.
  function automatic logic [63:0] lfsr_next(input logic [63:0] state,
                                            input logic [63:0] taps,
                                            input int          width);
    logic [63:0] mask;
    logic        fb;
    mask = '0;
    for (int i = 0; i < 64; i++) begin
      if (i < width) mask[i] = 1'b1;
    end
    fb = ~^(state & taps & mask);
    lfsr_next = ((state << 1) | {63'd0, fb}) & mask;
  endfunction

endpackage

// File: rtl/prng_lfsr_channel.sv
// One generator: LFSR state, control bits and step counter, updated on the falling edge.
module prng_lfsr_channel
  import prng_pkg::*;
#(
  parameter int          WIDTH   = 64,
  parameter logic [63:0] TAPS    = 64'hD800_0000_0000_0000,
  parameter logic [63:0] SEED    = 64'h128F_9A75_D093_C27E,
  parameter int          IDX     = 0,
  parameter int          COUNT_W = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               seed_we,
  input  logic [WIDTH-1:0]   seed_data,
  input  logic               ctrl_we,
  input  logic [1:0]         ctrl_data,
  input  logic               aor_req,
  output logic [WIDTH-1:0]   state,
  output logic [1:0]         ctrl,
  output logic [COUNT_W-1:0] count
);

  localparam logic [WIDTH-1:0] INIT = SEED[WIDTH-1:0] ^ WIDTH'(IDX);

  logic [63:0] state_ext;
  logic [63:0] next_ext;
  logic        step;

  always_comb begin
    state_ext = '0;
    state_ext[WIDTH-1:0] = state;
    next_ext = lfsr_next(state_ext, TAPS, WIDTH);
  end

  assign step = ctrl[CTRL_RUN] | (ctrl[CTRL_AOR] & aor_req);

  always_ff @(negedge clk) begin
    if (reset) begin
      state <= INIT;
      ctrl  <= 2'b01;
      count <= '0;
    end else begin
      // All-ones is the XNOR lock-up state, so it is replaced by the fallback seed.
      if (seed_we) begin
        state <= (&seed_data) ? SEED[WIDTH-1:0] : seed_data;
        count <= '0;
      end else if (step) begin
        state <= next_ext[WIDTH-1:0];
        count <= count + COUNT_W'(1);
      end
      if (ctrl_we) ctrl <= ctrl_data;
    end
  end

endmodule

// File: rtl/prng_bank.sv
// Bus-mapped bank of XNOR LFSR generators: address decode, read-edge detect, tri-state read mux.
module prng_bank
  import prng_pkg::*;
#(
  parameter logic [7:0]  BASE_ADDR = 8'h06,
  parameter int          WIDTH     = 64,
  parameter int          CHANNELS  = 4,
  parameter logic [63:0] TAPS      = 64'hD800_0000_0000_0000,
  parameter logic [63:0] SEED      = 64'h128F_9A75_D093_C27E,
  parameter int          COUNT_W   = 32
) (
  input  logic        procClock,
  input  logic        reset,
  inout  wire  [63:0] data,
  input  logic [63:0] address,
  input  logic        read,
  input  logic        write
);

  localparam int CB  = $clog2(CHANNELS);
  localparam int CIW = (CB < 1) ? 1 : CB;

  logic               sel;
  logic [CIW-1:0]     chan;
  logic [1:0]         offset;
  logic               chan_ok;
  logic               read_q;
  logic               rd_rise;
  logic [63:0]        rdata;
  logic               unused_addr;

  logic [WIDTH-1:0]   st [CHANNELS];
  logic [1:0]         ct [CHANNELS];
  logic [COUNT_W-1:0] cn [CHANNELS];

  assign sel         = (address[63:56] == BASE_ADDR);
  assign chan        = address[CIW+1:2];
  assign offset      = address[1:0];
  assign chan_ok     = (32'(chan) < CHANNELS);
  assign rd_rise     = read & ~read_q;
  assign unused_addr = ^address[55:CIW+2];

  always_ff @(negedge procClock) begin
    if (reset) read_q <= 1'b0;
    else       read_q <= read;
  end

  for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_ch
    logic hit;
    assign hit = sel & chan_ok & (32'(chan) == gi);

    prng_lfsr_channel #(
      .WIDTH(WIDTH), .TAPS(TAPS), .SEED(SEED), .IDX(gi), .COUNT_W(COUNT_W)
    ) u_ch (
      .clk      (procClock),
      .reset    (reset),
      .seed_we  (hit & write & (offset == REG_SEED)),
      .seed_data(data[WIDTH-1:0]),
      .ctrl_we  (hit & write & (offset == REG_CTRL)),
      .ctrl_data(data[1:0]),
      .aor_req  (hit & rd_rise & (offset == REG_VALUE)),
      .state    (st[gi]),
      .ctrl     (ct[gi]),
      .count    (cn[gi])
    );
  end

  // SEED is write-only and unmapped channels read as zero.
  always_comb begin
    rdata = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (chan_ok && (32'(chan) == i)) begin
        case (offset)
          REG_VALUE: rdata[WIDTH-1:0]   = st[i];
          REG_CTRL:  rdata[1:0]         = ct[i];
          REG_COUNT: rdata[COUNT_W-1:0] = cn[i];
          default:   rdata              = '0;
        endcase
      end
    end
  end

  assign data = (sel & read & ~reset) ? rdata : 64'bz;

endmodule

// File: tb/tb_prng_bank.sv
// Directed bench for prng_bank: a 64-bit 4-channel bank plus a 16-bit bank for the period sweep.
module tb_prng_bank;

  localparam logic [63:0] S64 = 64'h128F_9A75_D093_C27E;

  logic        clk = 1'b0;
  logic        reset, reset2;
  logic [63:0] address, addr2;
  logic        read, write;
  logic [63:0] drv;
  logic        drv_en;
  wire  [63:0] data;
  wire  [63:0] data2;

  int checks = 0;
  int errors = 0;

  logic [63:0] v;
  int          period;
  logic        saw_ff, upper_bad;

  always #5 clk = ~clk;

  assign data = drv_en ? drv : 64'bz;

  prng_bank dut (
    .procClock(clk), .reset(reset), .data(data),
    .address(address), .read(read), .write(write)
  );

  prng_bank #(
    .WIDTH(16), .CHANNELS(2), .TAPS(64'hB400), .SEED(64'hACE1), .COUNT_W(8)
  ) dut16 (
    .procClock(clk), .reset(reset2), .data(data2),
    .address(addr2), .read(1'b1), .write(1'b0)
  );

  function automatic logic [63:0] ra(input int ch, input int off);
    logic [63:0] a;
    a = {8'h06, 56'd0};
    a[5:2] = 4'(ch);
    a[1:0] = 2'(off);
    return a;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  // Short read pulse that never spans a falling edge, so it cannot trigger advance-on-read.
  task automatic peek(input logic [63:0] a, output logic [63:0] val);
    address = a;
    read = 1'b1;
    #1;
    val = data;
    read = 1'b0;
  endtask

  task automatic wr(input logic [63:0] a, input logic [63:0] val);
    address = a;
    drv = val;
    drv_en = 1'b1;
    write = 1'b1;
    tick(1);
    write = 1'b0;
    drv_en = 1'b0;
  endtask

  initial begin
    reset = 1'b1; reset2 = 1'b1; read = 1'b0; write = 1'b0;
    drv = '0; drv_en = 1'b0; address = '0; addr2 = ra(0, 0);
    tick(2);

    // Bench drives zeros; any DUT drive would disturb them.
    drv_en = 1'b1; drv = '0;
    peek(ra(0, 0), v); check("reset_release", v, 64'h0);
    drv_en = 1'b0;
    reset = 1'b0;

    peek(ra(0, 0), v); check("rst_ch0_value", v, S64);
    peek(ra(3, 0), v); check("rst_ch3_value", v, 64'h128F_9A75_D093_C27D);
    peek(ra(1, 0), v); check("rst_ch1_value", v, 64'h128F_9A75_D093_C27F);
    peek(ra(0, 2), v); check("rst_ch0_ctrl", v, 64'h1);
    peek(ra(0, 3), v); check("rst_ch0_count", v, 64'h0);
    peek(ra(2, 1), v); check("seed_reads_zero", v, 64'h0);
    drv_en = 1'b1;
    peek({8'h07, 56'd0}, v); check("base_mismatch_z", v, 64'h0);
    drv_en = 1'b0;

    tick(1);
    peek(ra(0, 0), v); check("ch0_step1", v, 64'h251F_34EB_A127_84FC);
    peek(ra(0, 3), v); check("ch0_count1", v, 64'h1);

    wr(ra(1, 2), 64'h2);
    wr(ra(1, 1), 64'h1);
    peek(ra(1, 2), v); check("ch1_ctrl_aor", v, 64'h2);
    peek(ra(1, 0), v); check("ch1_seeded", v, 64'h1);
    peek(ra(1, 3), v); check("ch1_count0", v, 64'h0);

    address = ra(1, 0); read = 1'b1; #1;
    check("aor_pre_edge", data, 64'h1);
    tick(1); check("aor_first_step", data, 64'h3);
    tick(4); check("aor_held_once", data, 64'h3);
    address = ra(1, 3); #1; check("aor_count1", data, 64'h1);
    read = 1'b0;
    tick(1);
    address = ra(1, 0); read = 1'b1; #1;
    check("aor_reassert_pre", data, 64'h3);
    tick(1); check("aor_second_step", data, 64'h7);
    address = ra(1, 3); #1; check("aor_count2", data, 64'h2);
    read = 1'b0;

    wr(ra(2, 2), 64'h0);
    wr(ra(2, 1), 64'hFFFF_FFFF_FFFF_FFFF);
    peek(ra(2, 0), v); check("lockup_guard", v, S64);
    peek(ra(2, 3), v); check("lockup_count0", v, 64'h0);
    tick(3);
    peek(ra(2, 0), v); check("run0_stable", v, S64);
    wr(ra(2, 0), 64'h5);
    wr(ra(2, 3), 64'h7);
    peek(ra(2, 0), v); check("value_wr_ignored", v, S64);
    peek(ra(2, 3), v); check("count_wr_ignored", v, 64'h0);
    wr(ra(2, 2), 64'hFFFF_FFFF_FFFF_FFFE);
    peek(ra(2, 2), v); check("ctrl_upper_masked", v, 64'h2);
    peek(ra(2, 0), v); check("ctrl_wr_keeps_state", v, S64);

    wr(ra(0, 2), 64'h0);
    wr(ra(0, 1), 64'h0123_4567_89AB_CDEF);
    tick(10);
    peek(ra(0, 0), v); check("ch0_frozen", v, 64'h0123_4567_89AB_CDEF);
    peek(ra(0, 3), v); check("ch0_frozen_count", v, 64'h0);

    wr(ra(3, 1), 64'h1);
    peek(ra(3, 0), v); check("seed_beats_step", v, 64'h1);
    peek(ra(3, 3), v); check("seed_clears_count", v, 64'h0);
    tick(1);
    peek(ra(3, 0), v); check("ch3_after_seed", v, 64'h3);
    peek(ra(3, 3), v); check("ch3_count1", v, 64'h1);

    // Reset coinciding with a seed write discards the write.
    address = ra(0, 1); drv = 64'h55; drv_en = 1'b1; write = 1'b1; reset = 1'b1;
    tick(1);
    write = 1'b0; drv_en = 1'b0; reset = 1'b0;
    peek(ra(0, 0), v); check("midop_rst_ch0", v, S64);
    peek(ra(0, 2), v); check("midop_rst_ctrl0", v, 64'h1);
    peek(ra(3, 0), v); check("midop_rst_ch3", v, 64'h128F_9A75_D093_C27D);
    peek(ra(1, 2), v); check("midop_rst_ctrl1", v, 64'h1);
    peek(ra(1, 3), v); check("midop_rst_count1", v, 64'h0);

    tick(1);
    reset2 = 1'b0;
    addr2 = ra(1, 0); #1; check("w16_rst_ch1", data2, 64'hACE0);
    addr2 = ra(0, 0); #1; check("w16_rst_ch0", data2, 64'hACE1);
    period = 0; saw_ff = 1'b0; upper_bad = 1'b0;
    for (int n = 1; n <= 70000; n++) begin
      @(negedge clk); #1;
      v = data2;
      if (v[15:0] == 16'hFFFF) saw_ff = 1'b1;
      if (v[63:16] != 48'd0) upper_bad = 1'b1;
      if (n == 1) check("w16_step1", v, 64'h59C2);
      if (n == 255 || n == 256) begin
        addr2 = ra(0, 3); #1;
        check("w16_count_wrap", data2, 64'(n % 256));
        addr2 = ra(0, 0); #1;
      end
      if (v[15:0] == 16'hACE1) begin
        period = n;
        break;
      end
    end
    check("w16_period", 64'(period), 64'd65535);
    check("w16_no_lockup", {63'd0, saw_ff}, 64'h0);
    check("w16_upper_zero", {63'd0, upper_bad}, 64'h0);
    addr2 = ra(0, 3); #1;
    check("w16_final_count", data2, 64'd255);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/prng_bank.md
Name: prng_bank

Overview:
- Memory-mapped bank of independent pseudo-random generators on the processor data bus. Each generator is a Fibonacci XNOR LFSR.
- Successor to the single fixed 64-bit generator: width, tap mask, seed and channel count are parametrised.
- Adds software-writable seeds, per-channel enable, advance-on-read mode and a per-channel step counter.
- Sits beside the other address-decoded peripherals and shares the common data/address/read/write bus.

Parameters:
- BASE_ADDR, 8'h06, value compared against address[63:56] for selection.
- WIDTH, 64, LFSR width in bits (8..64).
- CHANNELS, 4, number of independent generators (1..16, power of two).
- TAPS, 64'hD800_0000_0000_0000, tap mask over bits [WIDTH-1:0]. Default taps are bits 63,62,60,59.
- SEED, 64'h128F9A75D093C27E, reset/fallback seed; only bits [WIDTH-1:0] are used.

Ports:
- procClock  input  1  processor clock; all state updates on falling edge.
- reset  input  1  synchronous, active-high; sampled on falling edge of procClock.
- data  inout  64  bus data. Driven only during a selected read, else 64'bz.
- address  input  64  [63:56] block select, [CB+1:2] channel (CB = log2 CHANNELS), [1:0] register.
- read  input  1  bus read strobe.
- write  input  1  bus write strobe.

Behaviour:
- sel = (address[63:56] == BASE_ADDR). Register offsets:
  - 0 VALUE (RO): current LFSR state.
  - 1 SEED (WO): loads LFSR.
  - 2 CTRL (RW): bit0 RUN, bit1 AOR (advance-on-read); other bits read 0.
  - 3 COUNT (RO): 32-bit step counter.
- Read path is combinational. data = sel & read ? zero-extended register : 64'bz. VALUE reads return the pre-edge state.
- Step rule: feedback = ~XOR(state & TAPS[WIDTH-1:0]); next = {state[WIDTH-2:0], feedback}.
- A channel steps on a falling edge when RUN=1, or when AOR=1 and a read rising edge targets that channel's VALUE. At most one step per edge.
- Read rising edge = read & ~read_q, where read_q is registered on the falling edge. A held read advances an AOR channel once only.
- COUNT increments by 1 on every step and wraps 32'hFFFFFFFF -> 0.
- SEED write (sel & write, offset 1):
  - LFSR <= data[WIDTH-1:0]; COUNT <= 0.
  - If data[WIDTH-1:0] is all ones (XNOR lock-up state), load SEED[WIDTH-1:0] instead.
  - The write takes priority over a step in the same edge.
- CTRL write: bits [1:0] updated; state is unaffected.
- Writes to VALUE or COUNT are ignored.
- Simultaneous read and write to the same channel: data shows the pre-write value, and the write takes effect on the edge.
- Channel index >= CHANNELS: reads return 0; writes are ignored.
- Reset (overrides everything):
  - LFSR[i] = SEED[WIDTH-1:0] ^ i.
  - CTRL[i] = 2'b01 (RUN).
  - COUNT[i] = 0; read_q = 0.
  - data released to z.
- Reset mid-operation: any pending step or write in that edge is discarded.
- Register value to bus: zero-extended from WIDTH to 64 bits.

Decomposition:
- Shared package prng_pkg holds:
  - register offset constants (VALUE/SEED/CTRL/COUNT);
  - CTRL bit indices;
  - lfsr_next function.
- One sub-module, prng_lfsr_channel, instantiated CHANNELS times via generate. It holds state, CTRL, COUNT, seed-load with lock-up guard, and step logic.
- Top level does address decode, the read-edge detector and the tri-state data mux.

Test Plan:
- Reset, read ch0 VALUE -> 64'h128F9A75D093C27E. After one falling edge (RUN=1) -> 64'h251F34EBA12784FC, COUNT=1.
- Reset, read ch3 VALUE -> 64'h128F9A75D093C27D. Read with address[63:56]=8'h07 -> data is z.
- Write ch1 CTRL=2'b10 and SEED=64'h1. Hold read on ch1 VALUE for 5 cycles -> exactly one step. Then release, re-assert read -> second step, COUNT=2.
- Write ch2 SEED=64'hFFFFFFFFFFFFFFFF with RUN=0 -> VALUE reads 64'h128F9A75D093C27E, COUNT=0.
- Write ch0 CTRL=0 -> VALUE constant over 10 edges. Force COUNT near wrap via seed/steps in a 32-bit-count-shortened sim build -> wraps to 0.
- WIDTH=16, TAPS=16'hB400, SEED=16'hACE1 build, RUN=1 -> period 65535 steps. No state 16'hFFFF ever appears. Upper 48 data bits read 0.
